ring_counter_scanner: RTL and testbench
=======================================

# ring_counter_scanner

Sequential one-hot slot generator that drives the `ring_counter[2:0]` select bus of the 3x1 output multiplexer. A programmable prescaler stretches each slot to a fixed number of clock cycles, so downstream data/display stages are scanned in order 0 → 1 → 2 → 0. It also provides an encoded slot index and a wrap strobe for stages that must sample once per full scan.

## Interface
Parameters:
- `DIVIDER`, default 4: clock cycles per slot; legal range 1..65535.

Ports:
- `clock`, input, 1: single clock; all state updates on the rising edge.
- `reset_n`, input, 1: synchronous, active-low reset.
- `enable`, input, 1: advance permission; when low, all state holds.
- `restart`, input, 1: synchronous return to slot 0.
- `ring_counter`, output, 3: one-hot slot select, bit n = slot n active.
- `slot`, output, 2: encoded slot index, 0..2; value 3 is never driven.
- `wrap`, output, 1: one-cycle pulse when the scan returns from slot 2 to slot 0.

## Operation
- State: prescaler `count` with width max(1, $clog2(DIVIDER)), plus a one-hot `ring` register and `slot` register.
- Priority per edge: `reset_n`=0 > `restart`=1 > illegal-state recovery > advance > hold.
- Reset (`reset_n`=0 at an edge): `ring`=3'b001, `slot`=0, `count`=0, `wrap`=0. The output `ring_counter` is 3'b001, including when blanking is built in.
- Restart: same values as reset, regardless of `enable`. A restart in slot 2 does not assert `wrap`.
- Advance condition: `enable`=1 and `count`==DIVIDER-1. On that edge:
  - `count` goes to 0.
  - `ring` rotates left: 001→010→100→001.
  - `slot` increments modulo 3.
- Otherwise, with `enable`=1, `count` increments by 1.
- With `enable`=0, `count`, `ring` and `slot` all hold.
- `wrap` is registered. It is 1 for exactly the cycle following an advance from slot 2 to slot 0, and 0 at all other times, including while holding.
- Illegal-state recovery: if `ring` is not one of {001, 010, 100}, or `slot`==3, the next edge forces `ring`=001, `slot`=0, `count`=0 and `wrap`=0. This must be verifiable with `force`/`release`.
- DIVIDER=1: `count` is constant 0, and the block advances on every enabled edge.
- All outputs are driven directly from flops, with no combinational path from inputs to outputs.

## Timing
- Reference point: edge E0 is the first rising edge with `reset_n`=1; `enable` is held at 1 from E0 onward.
- Slot 0 output is visible from reset until edge E(DIVIDER-1). The block advances at that edge, so slot 1 is visible in the cycle after it.
- Each slot lasts exactly DIVIDER cycles; a full scan lasts 3·DIVIDER cycles.
- `wrap` is high during the first cycle of each new slot 0 that follows slot 2. It is never high during the slot 0 that immediately follows reset or restart.
- Latency from any input to an output is one edge:
  - `restart` registers on the edge where it is sampled high.
  - Deasserting `enable` freezes the outputs starting at the next edge.
- `restart` and the advance condition in the same cycle: restart wins, and `wrap` stays 0.

## Configuration
- Macro `RING_COUNTER_SCANNER_BLANKING_EN`.
- Defined: `ring_counter` is driven to 3'b000 during the last cycle of every slot, that is, while registered `count`==DIVIDER-1. This gives dead time for display anti-ghosting.
  - The blank indicator is a registered flag, so the output stays glitch-free.
  - `slot` and `wrap` are unaffected.
  - With DIVIDER=1, blanking is disabled and the output is never 000.
- Undefined: no blank flag is implemented, and `ring_counter` is always exactly the `ring` register.

## Test plan
- Free run, DIVIDER=4, `enable`=1 for 24 cycles:
  - Each `ring_counter` value (001, 010, 100) lasts 4 cycles, in the order 001, 010, 100, 001.
  - `slot` follows as 0, 1, 2, 0.
  - `wrap` is high exactly at cycles 12 and 24, and never in cycles 0–11.
- Enable gating, DIVIDER=4: drop `enable` for 5 cycles mid-slot 1. `ring_counter` holds at 010, `count` holds, and slot 1 totals 4 enabled cycles.
- Restart during slot 2 coinciding with the advance condition: the next cycle shows `ring_counter`=001, `slot`=0, `wrap`=0. The following slot 0 lasts 4 cycles.
- Reset mid-scan: `reset_n`=0 for one edge while in slot 1. Outputs become 001/0/0 after that edge, then the timing repeats exactly as in the first scenario.
- Illegal state: force `ring`=3'b110, then release. After one edge, `ring_counter`=001 and `slot`=0, and the scan resumes normally.
- DIVIDER=1 with `RING_COUNTER_SCANNER_BLANKING_EN` defined: the output rotates every cycle, is never 000, and `wrap` pulses every 3 cycles. Repeat with DIVIDER=4: `ring_counter` shows 000 on the 4th cycle of every slot.

Source files
------------

// File: rtl/ring_counter_scanner.sv
// One-hot 3-slot scan generator with per-slot prescaler, slot index and wrap strobe.
// Optional dead-time blanking of ring_counter: define RING_COUNTER_SCANNER_BLANKING_EN.
module ring_counter_scanner #(
   parameter int unsigned DIVIDER = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       enable,
   input  logic       restart,
   output logic [2:0] ring_counter,
   output logic [1:0] slot,
   output logic       wrap
);

   localparam int unsigned CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);

   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic [2:0]    ring;
   logic [2:0]    ring_nxt;
   logic [1:0]    slot_nxt;
   logic          wrap_nxt;
   logic          legal;

   assign legal = ((ring == 3'b001) || (ring == 3'b010) || (ring == 3'b100))
                  && (slot != 2'd3);

   always_comb begin
      count_nxt = count;
      ring_nxt  = ring;
      slot_nxt  = slot;
      wrap_nxt  = 1'b0;
      if (restart || !legal) begin
         count_nxt = '0;
         ring_nxt  = 3'b001;
         slot_nxt  = 2'd0;
      end else if (enable) begin
         if (count == LAST) begin
            count_nxt = '0;
            ring_nxt  = {ring[1:0], ring[2]};
            slot_nxt  = (slot == 2'd2) ? 2'd0 : slot + 2'd1;
            wrap_nxt  = (slot == 2'd2);
         end else begin
            count_nxt = count + CW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         count <= '0;
         ring  <= 3'b001;
         slot  <= 2'd0;
         wrap  <= 1'b0;
      end else begin
         count <= count_nxt;
         ring  <= ring_nxt;
         slot  <= slot_nxt;
         wrap  <= wrap_nxt;
      end
   end

`ifdef RING_COUNTER_SCANNER_BLANKING_EN
   // Blank flag is registered from next-state count so the output never glitches.
   localparam bit BLANK_OK = (DIVIDER > 1);

   logic blank;
   logic blank_nxt;

   assign blank_nxt = BLANK_OK && (count_nxt == LAST);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         blank <= 1'b0;
      end else begin
         blank <= blank_nxt;
      end
   end

   assign ring_counter = blank ? 3'b000 : ring;
`else
   assign ring_counter = ring;
`endif

endmodule

// File: tb/tb_ring_counter_scanner.sv
// Directed bench for ring_counter_scanner at DIVIDER=4 and DIVIDER=1.
module tb_ring_counter_scanner;

`ifdef RING_COUNTER_SCANNER_BLANKING_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset_n;
   logic       enable;
   logic       restart;
   logic [2:0] rc4;
   logic [1:0] sl4;
   logic       wr4;
   logic [2:0] rc1;
   logic [1:0] sl1;
   logic       wr1;

   int vectors = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   ring_counter_scanner #(.DIVIDER(4)) u_dut4 (
      .clock        (clock),
      .reset_n      (reset_n),
      .enable       (enable),
      .restart      (restart),
      .ring_counter (rc4),
      .slot         (sl4),
      .wrap         (wr4)
   );

   ring_counter_scanner #(.DIVIDER(1)) u_dut1 (
      .clock        (clock),
      .reset_n      (reset_n),
      .enable       (enable),
      .restart      (restart),
      .ring_counter (rc1),
      .slot         (sl1),
      .wrap         (wr1)
   );

   // Expected {ring_counter, slot, wrap} after n enabled edges since reset.
   function automatic logic [5:0] exp4(int n);
      int s;
      int c;
      logic [2:0] one;
      logic [2:0] rc;
      s   = (n / 4) % 3;
      c   = n % 4;
      one = 3'b001;
      rc  = one << s;
      if (BLANK && c == 3) rc = 3'b000;
      return {rc, 2'(s), (n > 0) && (n % 12 == 0)};
   endfunction

   function automatic logic [5:0] exp1(int n);
      int s;
      logic [2:0] one;
      s   = n % 3;
      one = 3'b001;
      return {one << s, 2'(s), (n > 0) && (s == 0)};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      enable  = 1'b0;
      restart = 1'b0;
      tick();
      reset_n = 1'b1;
      enable  = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      enable  = 1'b1;
      restart = 1'b0;
      tick();
      tick();
      vectors++;
      if ({rc4, sl4, wr4} !== 6'b001_00_0) begin
         miscompares++;
         $display("FAIL reset_d4 got %b want %b", {rc4, sl4, wr4}, 6'b001_00_0);
      end
      vectors++;
      if ({rc1, sl1, wr1} !== 6'b001_00_0) begin
         miscompares++;
         $display("FAIL reset_d1 got %b want %b", {rc1, sl1, wr1}, 6'b001_00_0);
      end
      vectors++;
      if (u_dut4.count !== 2'd0) begin
         miscompares++;
         $display("FAIL reset_count got %0d want 0", u_dut4.count);
      end
   endtask

   task automatic test_free_run();
      do_reset();
      for (int n = 1; n <= 24; n++) begin
         tick();
         vectors++;
         if ({rc4, sl4, wr4} !== exp4(n)) begin
            miscompares++;
            $display("FAIL free_run n=%0d got %b want %b", n, {rc4, sl4, wr4}, exp4(n));
         end
      end
   endtask

   task automatic test_enable_gating();
      do_reset();
      for (int n = 1; n <= 6; n++) tick();
      enable = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         vectors++;
         if ({rc4, sl4, wr4, u_dut4.count} !== {exp4(6), 2'd2}) begin
            miscompares++;
            $display("FAIL enable_hold k=%0d got %b want %b", k,
                     {rc4, sl4, wr4, u_dut4.count}, {exp4(6), 2'd2});
         end
      end
      enable = 1'b1;
      for (int n = 7; n <= 13; n++) begin
         tick();
         vectors++;
         if ({rc4, sl4, wr4} !== exp4(n)) begin
            miscompares++;
            $display("FAIL enable_resume n=%0d got %b want %b", n, {rc4, sl4, wr4}, exp4(n));
         end
      end
   endtask

   task automatic test_restart();
      do_reset();
      for (int n = 1; n <= 11; n++) tick();
      restart = 1'b1;
      tick();
      restart = 1'b0;
      vectors++;
      if ({rc4, sl4, wr4} !== 6'b001_00_0) begin
         miscompares++;
         $display("FAIL restart got %b want %b", {rc4, sl4, wr4}, 6'b001_00_0);
      end
      for (int n = 1; n <= 5; n++) begin
         tick();
         vectors++;
         if ({rc4, sl4, wr4} !== exp4(n)) begin
            miscompares++;
            $display("FAIL restart_run n=%0d got %b want %b", n, {rc4, sl4, wr4}, exp4(n));
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int n = 1; n <= 5; n++) tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      vectors++;
      if ({rc4, sl4, wr4} !== 6'b001_00_0) begin
         miscompares++;
         $display("FAIL reset_mid got %b want %b", {rc4, sl4, wr4}, 6'b001_00_0);
      end
      for (int n = 1; n <= 12; n++) begin
         tick();
         vectors++;
         if ({rc4, sl4, wr4} !== exp4(n)) begin
            miscompares++;
            $display("FAIL reset_mid_run n=%0d got %b want %b", n, {rc4, sl4, wr4}, exp4(n));
         end
      end
   endtask

   task automatic test_illegal();
      do_reset();
      for (int n = 1; n <= 5; n++) tick();
      force u_dut4.ring = 3'b110;
      #1;
      release u_dut4.ring;
      tick();
      vectors++;
      if ({rc4, sl4, wr4, u_dut4.count} !== {6'b001_00_0, 2'd0}) begin
         miscompares++;
         $display("FAIL illegal_recover got %b want %b",
                  {rc4, sl4, wr4, u_dut4.count}, {6'b001_00_0, 2'd0});
      end
      for (int n = 1; n <= 5; n++) begin
         tick();
         vectors++;
         if ({rc4, sl4, wr4} !== exp4(n)) begin
            miscompares++;
            $display("FAIL illegal_run n=%0d got %b want %b", n, {rc4, sl4, wr4}, exp4(n));
         end
      end
   endtask

   task automatic test_divider1();
      do_reset();
      for (int n = 1; n <= 9; n++) begin
         tick();
         vectors++;
         if ({rc1, sl1, wr1} !== exp1(n)) begin
            miscompares++;
            $display("FAIL div1 n=%0d got %b want %b", n, {rc1, sl1, wr1}, exp1(n));
         end
      end
      vectors++;
      if (u_dut1.count !== 1'b0) begin
         miscompares++;
         $display("FAIL div1_count got %0d want 0", u_dut1.count);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      enable  = 1'b0;
      restart = 1'b0;
      test_reset();
      test_free_run();
      test_enable_gating();
      test_restart();
      test_reset_mid();
      test_illegal();
      test_divider1();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
